// File: rtl/counter_sequencer_ctrl_pkg.sv
// counter_sequencer_ctrl_pkg: shared state and command encodings for the counter run controller.
package counter_sequencer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;

endpackage

// File: rtl/counter_sequencer_ctrl_datapath.sv
// counter_datapath_updown: loadable up/down count register with look-ahead modulo-wrap flag.
module counter_datapath_updown
  import counter_sequencer_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_nxt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en) begin
      count <= (dir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

  // High when the step about to be taken crosses all-ones <-> zero.
  assign wrap_nxt = en & ~ld & ((dir == DIR_UP) ? (&count) : ~(|count));

endmodule

// File: rtl/counter_sequencer_ctrl.sv
// counter_sequencer_ctrl: Start/Stop/Pause sequencer around a prescaled up/down counter with
// one-shot or auto-reload terminal handling and registered Done/Wrap pulses.
module counter_sequencer_ctrl
  import counter_sequencer_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic             Mode,
  input  logic             Dir,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] TermVal,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Wrap
);

  localparam int            PW      = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] ps, ps_nxt;
  logic          ld, en, done_nxt, wrap_nxt, dp_wrap, tick;

  counter_datapath_updown #(.WIDTH(WIDTH)) u_dp (
    .clk     (Clk),
    .rst     (Clr),
    .ld      (ld),
    .en      (en),
    .dir     (Dir),
    .ld_val  (LoadVal),
    .count   (Count),
    .wrap_nxt(dp_wrap)
  );

  assign tick = (ps == PS_LAST);
  assign Busy = (state == ST_RUN) || (state == ST_PAUSED);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= ST_IDLE;
      ps    <= '0;
      Done  <= 1'b0;
      Wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      ps    <= ps_nxt;
      Done  <= done_nxt;
      Wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ps_nxt    = ps;
    ld        = 1'b0;
    en        = 1'b0;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Stop) begin
          ld        = 1'b1;
          ps_nxt    = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          state_nxt = ST_IDLE;
        end else if (Start) begin
          ld     = 1'b1;
          ps_nxt = '0;
        end else if (Pause) begin
          state_nxt = ST_PAUSED;
        end else begin
          ps_nxt = tick ? '0 : ps + PW'(1);
          if (tick) begin
            if (Count == TermVal) begin
              done_nxt = 1'b1;
              if (Mode == MODE_RELOAD) ld = 1'b1;
              else                     state_nxt = ST_DONE;
            end else begin
              en       = 1'b1;
              wrap_nxt = dp_wrap;
            end
          end
        end
      end
      ST_PAUSED: begin
        // Resuming does not tick; the prescaler continues from where it froze.
        if (Stop) begin
          state_nxt = ST_IDLE;
        end else if (Start) begin
          ld        = 1'b1;
          ps_nxt    = '0;
          state_nxt = ST_RUN;
        end else if (!Pause) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        if (Start && !Stop) begin
          ld        = 1'b1;
          ps_nxt    = '0;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer_ctrl.sv
// Bench for counter_sequencer_ctrl: directed scenarios plus randomized run against a reference model.
module tb_counter_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0, dir = 1'b1;
  logic [3:0] load_val = '0, term_val = '0;
  logic [3:0] cnt1, cnt3;
  logic       busy1, done1, wrap1, busy3, done3, wrap3;

  int total  = 0;
  int passed = 0;

  always #20 clk = ~clk;

  counter_sequencer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .Clk(clk), .Clr(clr), .Start(start), .Stop(stop), .Pause(pause), .Mode(mode), .Dir(dir),
    .LoadVal(load_val), .TermVal(term_val), .Count(cnt1), .Busy(busy1), .Done(done1), .Wrap(wrap1)
  );

  counter_sequencer_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .Clk(clk), .Clr(clr), .Start(start), .Stop(stop), .Pause(pause), .Mode(mode), .Dir(dir),
    .LoadVal(load_val), .TermVal(term_val), .Count(cnt3), .Busy(busy3), .Done(done3), .Wrap(wrap3)
  );

  // Reference model, one slot per instance (prescale 1 and 3).
  int m_cnt [2];
  int m_el  [2];
  bit m_run [2], m_pau [2], m_dst [2], m_done [2], m_wrap [2];
  int m_ps  [2] = '{1, 3};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_cnt[i] = 0; m_el[i] = 0;
        m_run[i] = 0; m_pau[i] = 0; m_dst[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
      end else begin
        m_done[i] = 0; m_wrap[i] = 0;
        if (stop) begin
          m_run[i] = 0; m_pau[i] = 0; m_dst[i] = 0;
        end else if (start) begin
          m_cnt[i] = load_val; m_el[i] = 0;
          m_run[i] = 1; m_pau[i] = 0; m_dst[i] = 0;
        end else if (m_run[i] && pause) begin
          m_run[i] = 0; m_pau[i] = 1;
        end else if (m_run[i]) begin
          m_el[i]++;
          if (m_el[i] == m_ps[i]) begin
            m_el[i] = 0;
            if (m_cnt[i] == term_val) begin
              m_done[i] = 1;
              if (mode) m_cnt[i] = load_val;
              else begin m_run[i] = 0; m_dst[i] = 1; end
            end else if (dir) begin
              m_wrap[i] = (m_cnt[i] == 15);
              m_cnt[i]  = (m_cnt[i] + 1) % 16;
            end else begin
              m_wrap[i] = (m_cnt[i] == 0);
              m_cnt[i]  = (m_cnt[i] + 15) % 16;
            end
          end
        end else if (m_pau[i] && !pause) begin
          m_run[i] = 1; m_pau[i] = 0;
        end else if (m_dst[i]) begin
          m_dst[i] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1; start = 1; stop = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({cnt1, busy1, done1, wrap1} !== 7'h00 || {cnt3, busy3, done3, wrap3} !== 7'h00)
        $display("FAIL reset[%0d]: got %h/%h want 00/00", i, {cnt1, busy1, done1, wrap1},
                 {cnt3, busy3, done3, wrap3});
      else passed++;
    end
    clr = 0; start = 0;
  endtask

  task automatic test_oneshot();
    int c[7] = '{3, 4, 5, 6, 7, 7, 7};
    bit b[7] = '{1, 1, 1, 1, 1, 0, 0};
    bit d[7] = '{0, 0, 0, 0, 0, 1, 0};
    mode = 0; dir = 1; load_val = 3; term_val = 7; start = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 0;
      total++;
      if ({cnt1, busy1, done1, wrap1} !== {4'(c[i]), b[i], d[i], 1'b0})
        $display("FAIL oneshot[%0d]: got %h want %h", i, {cnt1, busy1, done1, wrap1},
                 {4'(c[i]), b[i], d[i], 1'b0});
      else passed++;
    end
  endtask

  task automatic test_reload();
    int c[9] = '{1, 0, 15, 14, 1, 0, 15, 14, 1};
    bit d[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    bit w[9] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    mode = 1; dir = 0; load_val = 1; term_val = 14; start = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      start = 0;
      total++;
      if ({cnt1, busy1, done1, wrap1} !== {4'(c[i]), 1'b1, d[i], w[i]})
        $display("FAIL reload[%0d]: got %h want %h", i, {cnt1, busy1, done1, wrap1},
                 {4'(c[i]), 1'b1, d[i], w[i]});
      else passed++;
    end
    stop = 1;
    step();
    stop = 0;
  endtask

  task automatic test_pause_stop();
    bit st[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    bit pa[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    bit sp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int c[9]  = '{2, 3, 4, 4, 4, 4, 4, 5, 5};
    bit b[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    mode = 0; dir = 1; load_val = 2; term_val = 15;
    for (int i = 0; i < 9; i++) begin
      start = st[i]; pause = pa[i]; stop = sp[i];
      step();
      total++;
      if ({cnt1, busy1, done1, wrap1} !== {4'(c[i]), b[i], 2'b00})
        $display("FAIL pause_stop[%0d]: got %h want %h", i, {cnt1, busy1, done1, wrap1},
                 {4'(c[i]), b[i], 2'b00});
      else passed++;
    end
    start = 0; pause = 0; stop = 0;
  endtask

  task automatic test_restart_clr();
    bit st[8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    int lv[8] = '{2, 2, 2, 2, 2, 9, 9, 9};
    int c[8]  = '{2, 3, 4, 5, 6, 9, 10, 11};
    mode = 0; dir = 1; term_val = 15;
    for (int i = 0; i < 8; i++) begin
      start = st[i]; load_val = 4'(lv[i]);
      step();
      total++;
      if ({cnt1, busy1, done1, wrap1} !== {4'(c[i]), 3'b100})
        $display("FAIL restart[%0d]: got %h want %h", i, {cnt1, busy1, done1, wrap1},
                 {4'(c[i]), 3'b100});
      else passed++;
    end
    start = 0; clr = 1;
    step();
    clr = 0;
    total++;
    if ({cnt1, busy1, done1, wrap1} !== 7'h00 || {cnt3, busy3, done3, wrap3} !== 7'h00)
      $display("FAIL clr_midrun: got %h/%h want 00/00", {cnt1, busy1, done1, wrap1},
               {cnt3, busy3, done3, wrap3});
    else passed++;
  endtask

  task automatic test_prescale();
    bit st[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit pa[14] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int c[14]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2};
    bit b[14]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit d[14]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    mode = 0; dir = 1; load_val = 0; term_val = 2;
    for (int i = 0; i < 14; i++) begin
      start = st[i]; pause = pa[i];
      step();
      total++;
      if ({cnt3, busy3, done3, wrap3} !== {4'(c[i]), b[i], d[i], 1'b0})
        $display("FAIL prescale[%0d]: got %h want %h", i, {cnt3, busy3, done3, wrap3},
                 {4'(c[i]), b[i], d[i], 1'b0});
      else passed++;
    end
    start = 0; pause = 0;
  endtask

  task automatic test_random();
    clr = 1;
    step();
    clr = 0;
    for (int n = 0; n < 600; n++) begin
      clr   = ($urandom_range(0, 79) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 11) == 0);
      pause = ($urandom_range(0, 5) == 0);
      mode  = 1'($urandom_range(0, 1));
      dir   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) term_val = 4'($urandom_range(0, 15));
      step();
      total++;
      if ({cnt1, busy1, done1, wrap1} !== {4'(m_cnt[0]), m_run[0] | m_pau[0], m_done[0], m_wrap[0]})
        $display("FAIL random_p1[%0d]: got %h want %h", n, {cnt1, busy1, done1, wrap1},
                 {4'(m_cnt[0]), m_run[0] | m_pau[0], m_done[0], m_wrap[0]});
      else passed++;
      total++;
      if ({cnt3, busy3, done3, wrap3} !== {4'(m_cnt[1]), m_run[1] | m_pau[1], m_done[1], m_wrap[1]})
        $display("FAIL random_p3[%0d]: got %h want %h", n, {cnt3, busy3, done3, wrap3},
                 {4'(m_cnt[1]), m_run[1] | m_pau[1], m_done[1], m_wrap[1]});
      else passed++;
    end
    clr = 0; stop = 0; start = 0; pause = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_reload();
    test_pause_stop();
    test_restart_clr();
    test_prescale();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
